// File: rtl/a51_pkg.sv
// Shared types and default sizes for the A5/1 keystream sequencer.
package a51_pkg;

    localparam int A51_KEY_BITS   = 64;
    localparam int A51_FRAME_BITS = 22;
    localparam int A51_MIX_STEPS  = 100;
    localparam int A51_KS_BITS    = 228;
    localparam int A51_WORD_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD_KEY,
        ST_LOAD_FRAME,
        ST_MIX,
        ST_GEN,
        ST_FLUSH
    } a51_state_e;

    function automatic int a51_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/a51_ks_packer.sv
// Packs serial keystream bits MSB-first into 32-bit words behind a valid/ready output register.
module a51_ks_packer
    import a51_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_bit_valid,
    input  logic                  i_bit,
    input  logic                  i_bit_last,
    input  logic                  i_ready,
    output logic [A51_WORD_W-1:0] o_word,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_full
);

    localparam int BIT_W = $clog2(A51_WORD_W);

    logic [A51_WORD_W-1:0] r_sh;
    logic [BIT_W-1:0]      r_cnt;
    logic                  r_full;
    logic                  r_fullLast;
    logic                  r_spare;
    logic                  r_spareValid;
    logic                  r_spareLast;
    logic [A51_WORD_W-1:0] r_word;
    logic                  r_valid;
    logic                  r_last;

    logic [A51_WORD_W-1:0] w_sh;
    logic [BIT_W-1:0]      w_cnt;
    logic                  w_full;
    logic                  w_fullLast;
    logic                  w_spare;
    logic                  w_spareValid;
    logic                  w_spareLast;
    logic [A51_WORD_W-1:0] w_word;
    logic                  w_valid;
    logic                  w_last;
    logic                  w_outBusy;
    logic                  w_inValid;
    logic                  w_in;
    logic                  w_inLast;
    logic [A51_WORD_W-1:0] w_baseSh;
    logic [BIT_W-1:0]      w_baseCnt;
    logic [A51_WORD_W-1:0] w_asm;

    // A stalled full word keeps one spare slot for the bit already in flight from the core.
    always_comb begin
        w_sh         = r_sh;
        w_cnt        = r_cnt;
        w_full       = r_full;
        w_fullLast   = r_fullLast;
        w_spare      = r_spare;
        w_spareValid = r_spareValid;
        w_spareLast  = r_spareLast;
        w_word       = r_word;
        w_valid      = r_valid;
        w_last       = r_last;
        w_outBusy    = r_valid & ~i_ready;
        w_inValid    = i_bit_valid;
        w_in         = i_bit;
        w_inLast     = i_bit_last;
        w_baseSh     = r_sh;
        w_baseCnt    = r_cnt;
        w_asm        = '0;

        if (r_valid && i_ready) begin
            w_valid = 1'b0;
            w_last  = 1'b0;
        end

        if (r_full) begin
            if (!w_outBusy) begin
                w_word       = r_sh;
                w_valid      = 1'b1;
                w_last       = r_fullLast;
                w_full       = 1'b0;
                w_fullLast   = 1'b0;
                w_outBusy    = 1'b1;
                w_baseSh     = '0;
                w_baseCnt    = '0;
                w_spareValid = 1'b0;
                w_spareLast  = 1'b0;
                if (r_spareValid) begin
                    w_inValid = 1'b1;
                    w_in      = r_spare;
                    w_inLast  = r_spareLast;
                end
            end else begin
                w_inValid = 1'b0;
                if (i_bit_valid) begin
                    w_spare      = i_bit;
                    w_spareLast  = i_bit_last;
                    w_spareValid = 1'b1;
                end
            end
        end

        if (w_inValid) begin
            w_asm = w_baseSh;
            w_asm[BIT_W'(A51_WORD_W-1) - w_baseCnt] = w_in;
            if ((w_baseCnt == BIT_W'(A51_WORD_W-1)) || w_inLast) begin
                w_cnt = '0;
                if (w_outBusy) begin
                    w_sh       = w_asm;
                    w_full     = 1'b1;
                    w_fullLast = w_inLast;
                end else begin
                    w_sh    = '0;
                    w_word  = w_asm;
                    w_valid = 1'b1;
                    w_last  = w_inLast;
                end
            end else begin
                w_sh  = w_asm;
                w_cnt = w_baseCnt + 1'b1;
            end
        end else begin
            w_sh  = w_baseSh;
            w_cnt = w_baseCnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || i_clear) begin
            r_sh         <= '0;
            r_cnt        <= '0;
            r_full       <= 1'b0;
            r_fullLast   <= 1'b0;
            r_spare      <= 1'b0;
            r_spareValid <= 1'b0;
            r_spareLast  <= 1'b0;
            r_word       <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_sh         <= w_sh;
            r_cnt        <= w_cnt;
            r_full       <= w_full;
            r_fullLast   <= w_fullLast;
            r_spare      <= w_spare;
            r_spareValid <= w_spareValid;
            r_spareLast  <= w_spareLast;
            r_word       <= w_word;
            r_valid      <= w_valid;
            r_last       <= w_last;
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_full  = r_full;

endmodule

// File: rtl/a51_sequencer.sv
// Drives an external A5/1 core through clear/key/frame load, warm-up and keystream generation.
module a51_sequencer
    import a51_pkg::*;
#(
    parameter int KEY_BITS   = A51_KEY_BITS,
    parameter int FRAME_BITS = A51_FRAME_BITS,
    parameter int MIX_STEPS  = A51_MIX_STEPS,
    parameter int KS_BITS    = A51_KS_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    output logic                  done,
    output logic [A51_WORD_W-1:0] ks_word,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic                  ks_last,
    output logic                  core_clear,
    output logic                  core_load_en,
    output logic                  core_load_bit,
    output logic                  core_step,
    input  logic                  core_ks_bit
);

    localparam int MAX_CNT = a51_max4(KEY_BITS, FRAME_BITS, MIX_STEPS, KS_BITS);
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    a51_state_e            r_state;
    a51_state_e            w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [KEY_BITS-1:0]   r_key;
    logic [FRAME_BITS-1:0] r_frame;
    logic                  r_capture;
    logic                  r_captureLast;

    logic w_abort;
    logic w_step;
    logic w_genStep;
    logic w_lastAccepted;
    logic w_packFull;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Steps are held off only while a finished word is stalled behind an occupied output.
    always_comb begin
        w_next         = r_state;
        w_abort        = abort && (r_state != ST_IDLE);
        w_lastAccepted = ks_valid && ks_ready && ks_last;
        w_step         = (r_state == ST_MIX) ||
                         ((r_state == ST_GEN) && !(w_packFull && ks_valid));
        w_genStep      = (r_state == ST_GEN) && w_step;
        busy           = (r_state != ST_IDLE);
        core_clear     = (r_state == ST_CLEAR);
        core_load_en   = (r_state == ST_LOAD_KEY) || (r_state == ST_LOAD_FRAME);
        core_load_bit  = 1'b0;
        core_step      = w_step;
        done           = (r_state == ST_FLUSH) && w_lastAccepted && !w_abort;

        case (r_state)
            ST_IDLE:       if (start && !abort) w_next = ST_CLEAR;
            ST_CLEAR:      w_next = ST_LOAD_KEY;
            ST_LOAD_KEY: begin
                core_load_bit = r_key[0];
                if (r_cnt == CNT_W'(KEY_BITS-1)) w_next = ST_LOAD_FRAME;
            end
            ST_LOAD_FRAME: begin
                core_load_bit = r_frame[0];
                if (r_cnt == CNT_W'(FRAME_BITS-1)) w_next = ST_MIX;
            end
            ST_MIX:        if (r_cnt == CNT_W'(MIX_STEPS-1)) w_next = ST_GEN;
            ST_GEN:        if (w_step && (r_cnt == CNT_W'(KS_BITS-1))) w_next = ST_FLUSH;
            ST_FLUSH:      if (w_lastAccepted) w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase

        if (w_abort) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt         <= '0;
            r_key         <= '0;
            r_frame       <= '0;
            r_capture     <= 1'b0;
            r_captureLast <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_LOAD_KEY) || (r_state == ST_LOAD_FRAME) ||
                         (r_state == ST_MIX) || w_genStep) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == ST_IDLE) && start && !abort) begin
                r_key   <= key;
                r_frame <= frame;
            end else if (r_state == ST_LOAD_KEY) begin
                r_key <= r_key >> 1;
            end else if (r_state == ST_LOAD_FRAME) begin
                r_frame <= r_frame >> 1;
            end

            r_capture     <= w_genStep && !w_abort;
            r_captureLast <= w_genStep && !w_abort && (r_cnt == CNT_W'(KS_BITS-1));
        end
    end

    a51_ks_packer u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (w_abort),
        .i_bit_valid (r_capture),
        .i_bit       (core_ks_bit),
        .i_bit_last  (r_captureLast),
        .i_ready     (ks_ready),
        .o_word      (ks_word),
        .o_valid     (ks_valid),
        .o_last      (ks_last),
        .o_full      (w_packFull)
    );

endmodule

// File: tb/tb_a51_sequencer.sv
// Bench for a51_sequencer: behavioural A5/1 core, software keystream model and word scoreboard.
module tb_a51_sequencer;

    localparam int KB = 64;
    localparam int FB = 22;
    localparam int MS = 100;
    localparam int KSB = 228;
    localparam int NW = (KSB + 31) / 32;
    localparam int TOTAL_STEPS = MS + KSB;

    typedef struct {
        logic [31:0] word;
        logic        last;
    } exp_t;

    typedef struct {
        logic [63:0] key;
        logic [21:0] frame;
        int          duty;
        bit          extraStarts;
        int          expWords;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [KB-1:0] key = '0;
    logic [FB-1:0] frame = '0;
    logic          busy;
    logic          done;
    logic [31:0]   ks_word;
    logic          ks_valid;
    logic          ks_ready = 1'b1;
    logic          ks_last;
    logic          core_clear;
    logic          core_load_en;
    logic          core_load_bit;
    logic          core_step;
    logic          core_ks_bit;

    int nCompared = 0;
    int nMismatched = 0;
    int readyDuty = 100;
    exp_t expQ[$];

    logic [63:0] curKey;
    logic [21:0] curFrame;
    int clearCnt, loadIdx, loadErr, stepCnt, exclErr, stepFullErr, holdErr, wordCnt, doneCnt;
    bit holdPending = 1'b0;
    logic [31:0] holdWord;
    logic holdLast;

    logic [63:0] coreSt = '0;

    a51_sequencer u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .key           (key),
        .frame         (frame),
        .busy          (busy),
        .done          (done),
        .ks_word       (ks_word),
        .ks_valid      (ks_valid),
        .ks_ready      (ks_ready),
        .ks_last       (ks_last),
        .core_clear    (core_clear),
        .core_load_en  (core_load_en),
        .core_load_bit (core_load_bit),
        .core_step     (core_step),
        .core_ks_bit   (core_ks_bit)
    );

    always #5 clk = ~clk;

    // State packing: [18:0] R1, [40:19] R2, [63:41] R3.
    function automatic logic [63:0] a51Clock(input logic [63:0] s, input logic useMaj, input logic b);
        logic [18:0] r1;
        logic [21:0] r2;
        logic [22:0] r3;
        logic m;
        r1 = s[18:0];
        r2 = s[40:19];
        r3 = s[63:41];
        m = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
        if (!useMaj || (r1[8] == m))  r1 = {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ b};
        if (!useMaj || (r2[10] == m)) r2 = {r2[20:0], r2[21] ^ r2[20] ^ b};
        if (!useMaj || (r3[10] == m)) r3 = {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ b};
        return {r3, r2, r1};
    endfunction

    always @(posedge clk) begin
        if (core_clear)        coreSt <= '0;
        else if (core_load_en) coreSt <= a51Clock(coreSt, 1'b0, core_load_bit);
        else if (core_step)    coreSt <= a51Clock(coreSt, 1'b1, 1'b0);
    end
    assign core_ks_bit = coreSt[18] ^ coreSt[40] ^ coreSt[63];

    always @(posedge clk) begin
        #1;
        ks_ready = (readyDuty >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyDuty);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic swModel(input logic [63:0] k, input logic [21:0] f, output logic [NW-1:0][31:0] ws);
        logic [63:0] s;
        s = '0;
        ws = '0;
        for (int i = 0; i < KB; i++) s = a51Clock(s, 1'b0, k[i]);
        for (int i = 0; i < FB; i++) s = a51Clock(s, 1'b0, f[i]);
        for (int i = 0; i < MS; i++) s = a51Clock(s, 1'b1, 1'b0);
        for (int i = 0; i < KSB; i++) begin
            s = a51Clock(s, 1'b1, 1'b0);
            ws[i / 32][31 - (i % 32)] = s[18] ^ s[40] ^ s[63];
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            holdPending = 1'b0;
        end else begin
            if (core_clear) clearCnt++;
            if (core_load_en) begin
                if (loadIdx < KB) begin
                    if (core_load_bit !== curKey[loadIdx]) loadErr++;
                end else if (loadIdx < KB + FB) begin
                    if (core_load_bit !== curFrame[loadIdx - KB]) loadErr++;
                end else begin
                    loadErr++;
                end
                loadIdx++;
            end
            if (core_step) stepCnt++;
            if ((32'(core_clear) + 32'(core_load_en) + 32'(core_step)) > 1) exclErr++;
            if (!busy && (core_clear || core_load_en || core_step)) exclErr++;
            if (core_step && u_dut.w_packFull && ks_valid) stepFullErr++;
            if (holdPending && !(ks_valid && ks_word == holdWord && ks_last == holdLast)) holdErr++;
            holdPending = ks_valid && !ks_ready;
            holdWord = ks_word;
            holdLast = ks_last;
            if (ks_valid && ks_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_word", 64'(ks_word), 64'hdead_0000_0000_0000);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("ks_word", 64'(ks_word), 64'(e.word));
                    checkOutput("ks_last", 64'(ks_last), 64'(e.last));
                end
                wordCnt++;
            end
            if (done) begin
                doneCnt++;
                checkOutput("done_with_last", 64'(ks_valid && ks_ready && ks_last), 64'd1);
            end
        end
    end

    task automatic beginRun(input logic [63:0] k, input logic [21:0] f, input bit pushExp);
        logic [NW-1:0][31:0] ws;
        exp_t e;
        curKey = k;
        curFrame = f;
        clearCnt = 0; loadIdx = 0; loadErr = 0; stepCnt = 0; exclErr = 0;
        stepFullErr = 0; holdErr = 0; wordCnt = 0; doneCnt = 0;
        expQ.delete();
        if (pushExp) begin
            swModel(k, f, ws);
            for (int w = 0; w < NW; w++) begin
                e.word = ws[w];
                e.last = (w == NW - 1);
                expQ.push_back(e);
            end
        end
    endtask

    task automatic waitRunEnd(input int expWords, input bit extraStarts);
        int cyc;
        int myStep;
        int flushPh;
        bit gotDone;
        cyc = 0; myStep = 0; flushPh = 0; gotDone = 1'b0;
        while (!gotDone && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (core_step) myStep++;
            start = 1'b0;
            if (extraStarts) begin
                if (core_step && myStep == 50) start = 1'b1;
                if (flushPh > 0 && flushPh < 3) start = 1'b1;
                if (flushPh > 0) flushPh++;
                if (core_step && myStep == TOTAL_STEPS) flushPh = 1;
            end
            if (done) gotDone = 1'b1;
        end
        checkOutput("done_seen", 64'(gotDone), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_after_run", 64'(busy), 64'd0);
        checkOutput("word_count", 64'(wordCnt), 64'(expWords));
        checkOutput("done_count", 64'(doneCnt), 64'd1);
        checkOutput("clear_cycles", 64'(clearCnt), 64'd1);
        checkOutput("load_cycles", 64'(loadIdx), 64'(KB + FB));
        checkOutput("load_bit_errors", 64'(loadErr), 64'd0);
        checkOutput("step_count", 64'(stepCnt), 64'(TOTAL_STEPS));
        checkOutput("exclusive_errors", 64'(exclErr), 64'd0);
        checkOutput("step_while_full", 64'(stepFullErr), 64'd0);
        checkOutput("hold_errors", 64'(holdErr), 64'd0);
        checkOutput("queue_left", 64'(expQ.size()), 64'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        readyDuty = v.duty;
        beginRun(v.key, v.frame, 1'b1);
        @(posedge clk);
        #1;
        key = v.key;
        frame = v.frame;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        waitRunEnd(v.expWords, v.extraStarts);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_ks_valid"}, 64'(ks_valid), 64'd0);
        checkOutput({tag, "_ks_last"}, 64'(ks_last), 64'd0);
        checkOutput({tag, "_ks_word"}, 64'(ks_word), 64'd0);
        checkOutput({tag, "_core_clear"}, 64'(core_clear), 64'd0);
        checkOutput({tag, "_core_load_en"}, 64'(core_load_en), 64'd0);
        checkOutput({tag, "_core_load_bit"}, 64'(core_load_bit), 64'd0);
        checkOutput({tag, "_core_step"}, 64'(core_step), 64'd0);
    endtask

    vec_t vecs[4];

    initial begin
        int cyc;
        int myStep;
        int lc;
        vecs[0] = '{key: 64'h1223456789ABCDEF, frame: 22'h134,    duty: 100, extraStarts: 1'b0, expWords: NW};
        vecs[1] = '{key: 64'h1223456789ABCDEF, frame: 22'h134,    duty: 30,  extraStarts: 1'b0, expWords: NW};
        vecs[2] = '{key: 64'hFEDCBA9876543210, frame: 22'h3FFFFF, duty: 100, extraStarts: 1'b1, expWords: NW};
        vecs[3] = '{key: 64'h0F1E2D3C4B5A6978, frame: 22'h00A5C3, duty: 50,  extraStarts: 1'b1, expWords: NW};

        #2;
        checkAllZero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end

        // start coincident with abort in IDLE must not launch a run
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_with_abort", 64'(busy), 64'd0);

        // abort on the 10th keystream step, then an immediate new run
        readyDuty = 100;
        beginRun(64'h1223456789ABCDEF, 22'h134, 1'b0);
        key = 64'h1223456789ABCDEF;
        frame = 22'h134;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        myStep = 0;
        while (myStep < MS + 10 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (core_step) myStep++;
        end
        checkOutput("abort_step_reached", 64'(myStep), 64'(MS + 10));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_ks_valid", 64'(ks_valid), 64'd0);
        checkOutput("abort_core_step", 64'(core_step), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 64'(doneCnt), 64'd0);
        checkOutput("abort_no_words", 64'(wordCnt), 64'd0);
        applyStimulus(vecs[0]);

        // asynchronous reset between edges in the middle of key loading
        beginRun(64'h1223456789ABCDEF, 22'h134, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        lc = 0;
        while (lc < 20 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (core_load_en) lc++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        beginRun(vecs[2].key, vecs[2].frame, 1'b1);
        key = vecs[2].key;
        frame = vecs[2].frame;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("first_edge_start", 64'(busy), 64'd1);
        waitRunEnd(NW, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
